// File: rtl/dct8_transpose_buffer.sv
// Ping-pong N x N transpose buffer between the row and column dct8 passes.
// One bank fills in row-major order while the other drains, either column-major or unchanged.
module dct8_transpose_buffer #(
    parameter int N      = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              transpose_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int DEPTH = N * N;
    localparam int LOG_N = $clog2(N);
    localparam int AW    = 2 * LOG_N;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [2][DEPTH];

    logic [1:0]    bank_full_q, bank_full_d;
    logic [1:0]    bank_tr_q, bank_tr_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;

    logic          wr_fire;
    logic          rd_fire;
    logic [AW-1:0] rd_addr;

    assign in_ready  = ~bank_full_q[wr_bank_q];
    assign out_valid = bank_full_q[rd_bank_q];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;

    // Transposed read: k -> (k mod N) * N + k / N, i.e. the two index halves swapped.
    assign rd_addr  = bank_tr_q[rd_bank_q] ? {rd_cnt_q[LOG_N-1:0], rd_cnt_q[AW-1:LOG_N]}
                                           : rd_cnt_q;
    assign out_data = out_valid ? mem_q[rd_bank_q][rd_addr] : '0;
    assign out_last = out_valid & (rd_cnt_q == LAST_IDX);

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        bank_full_d = bank_full_q;
        bank_tr_d   = bank_tr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;

        if (flush) begin
            bank_full_d = '0;
            bank_tr_d   = '0;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
        end else begin
            if (wr_fire) begin
                if (wr_cnt_q == '0) begin
                    bank_tr_d[wr_bank_q] = transpose_en;
                end
                if (wr_cnt_q == LAST_IDX) begin
                    bank_full_d[wr_bank_q] = 1'b1;
                    wr_bank_d              = ~wr_bank_q;
                    wr_cnt_d               = '0;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            // Write and read always target different banks, so both updates can land together.
            if (rd_fire) begin
                if (rd_cnt_q == LAST_IDX) begin
                    bank_full_d[rd_bank_q] = 1'b0;
                    rd_bank_d              = ~rd_bank_q;
                    rd_cnt_d               = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full_q <= '0;
            bank_tr_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            bank_tr_q   <= bank_tr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; bank_full gates every read, so stale words never escape.
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem_q[wr_bank_q][wr_cnt_q] <= in_data;
        end
    end

endmodule
